div_seq_ctrl: RTL and testbench
===============================

// Module: div_seq_ctrl
// PURPOSE
//  Multi-cycle integer divide sequencer for the EX stage. It serves DIV.W, DIV.WU, MOD.W and MOD.WU.
//  It runs a radix-2 restoring divider over DATA_W iterations and holds EX through a stall signal.
//  It presents a registered quotient or remainder to the ALU result mux.
//  It is flushed together with the pipeline on an exception or ERTN (csr_reset).
// PARAMETERS
//  DATA_W      32  operand/result width; iteration count = DATA_W
//  ZERO_BYPASS 1   1: divisor==0 skips iterations (DONE after 1 cycle); 0: iterate normally
// PORTS
//  clk         in   1       single clock, all state on posedge
//  reset       in   1       synchronous, active-high
//  flush       in   1       synchronous pipeline flush (csr_reset); same effect as reset
//  req_valid   in   1       EX holds a valid divide op; src/ctrl stable while high
//  req_signed  in   1       1: signed (DIV.W/MOD.W), 0: unsigned
//  req_mod     in   1       1: return remainder, 0: return quotient
//  req_src1    in   DATA_W  dividend
//  req_src2    in   DATA_W  divisor
//  out_ready   in   1       EX advancing this cycle (EX_ready_go & MEM_allow_in)
//  div_wait    out  1       stall EX; = req_valid & (state != DONE)
//  div_done    out  1       result valid (state == DONE)
//  div_result  out  DATA_W  registered quotient/remainder; valid only while div_done
// BEHAVIOUR
//  States: IDLE, ITER, DONE. Reset/flush -> IDLE, count=0, result reg=0, div_wait=0, div_done=0.
//  IDLE & req_valid (cycle N):
//   - latch |src1|, |src2| (abs only if req_signed), q_neg = signed & (s1[MSB]^s2[MSB]), r_neg = signed & s1[MSB]
//   - latch req_mod; clear remainder acc; count=0 -> ITER
//   - if ZERO_BYPASS & src2==0 -> DONE directly
//  ITER: each cycle shift {rem,dvd} left 1 bit, trial-subtract divisor, set q bit if no borrow; count++.
//   - on count==DATA_W-1: apply sign fix (q=-q if q_neg, r=-r if r_neg) -> div_result; go DONE
//   - latency: div_done at N+DATA_W+1 (N+33 for 32b); div_wait high cycles N..N+DATA_W
//  DONE: div_wait=0, div_done=1, result held stable.
//   - out_ready -> IDLE; else stay DONE; no restart of the same op
//   - back-to-back: a new op may start in the IDLE cycle immediately following
//  Divide by zero: q=all-ones (unsigned pattern before sign fix), r=src1 unchanged; no exception raised.
//  Overflow 0x80000000 / 0xFFFFFFFF signed: q=0x80000000, r=0 (falls out of abs/neg math in DATA_W bits).
//  Abs of 0x80000000 is 0x80000000 as unsigned; the datapath is DATA_W bits, with a DATA_W+1 bit trial subtract.
//  Abort: req_valid low in ITER or DONE (EX cancelled) -> IDLE next cycle, result discarded.
//  Simultaneous events:
//   - flush beats all others
//   - out_ready in ITER is ignored (div_wait already blocks EX from advancing)
//  Operand changes while req_valid is high and the state is not IDLE are ignored; latched copies are used.
// STRUCTURE
//  - State encodings (IDLE/ITER/DONE) and DIV_CNT_W = $clog2(DATA_W) go in constants.h.
//  - One sub-module div_step: combinational single iteration.
//    in {rem,dvd,divisor}, out {rem',dvd',qbit}.
//  - Sign fix and abs stay in div_seq_ctrl.
//  - The ALU ORs div_wait into alu_wait and selects div_result for div ops.
// TESTING
//  1. unsigned 100/7, req_mod=0 -> div_wait 33 cycles, div_result=14; req_mod=1 -> 2
//  2. signed -7/2 -> q=0xFFFFFFFD(-3); mod -> r=0xFFFFFFFF(-1); 7/-2 -> q=-3, r=1
//  3. 0x80000000/0xFFFFFFFF signed -> q=0x80000000, r=0; unsigned -> q=0, r=0x80000000
//  4. src2=0, ZERO_BYPASS=1 -> div_done at N+1, q=0xFFFFFFFF, r=src1 (src1=0x1234 -> r=0x1234)
//  5. flush at iteration 10 -> IDLE next cycle, div_wait=0;
//     new op 9/3 starts next cycle -> q=3 after 33 cycles
//  6. DONE with out_ready=0 for 5 cycles -> result held, no restart;
//     out_ready=1 then an immediate second op 50/5 -> q=10

Source files
------------

// File: rtl/div_seq_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Package     : div_seq_ctrl_pkg
// Description : Shared constants for the EX-stage divide sequencer. Holds the
//               sequencer state encodings and the iteration-counter width
//               helper.
// Revision    : 1.0 - initial release
// ============================================================================
package div_seq_ctrl_pkg;

    // Sequencer state encodings
    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_iter = 2'd1;
    localparam logic [1:0] c_st_done = 2'd2;

    // Iteration counter width (DIV_CNT_W) for a given operand width; never
    // narrower than one bit so degenerate widths still elaborate.
    function automatic int div_cnt_w(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage : div_seq_ctrl_pkg
`default_nettype wire

// File: rtl/div_step.sv
`default_nettype none
// ============================================================================
// Module      : div_step
// Description : One combinational radix-2 restoring-divide iteration.
//               Shifts {rem,dvd} left by one, trial-subtracts the divisor
//               from the widened partial remainder and restores on borrow.
// Ports       : i_rem     - partial remainder (DATA_W)
//               i_dvd     - remaining dividend / accumulated quotient bits
//               i_divisor - divisor magnitude
//               o_rem     - next partial remainder
//               o_dvd     - shifted dividend; LSB left 0 for the quotient bit
//               o_qbit    - quotient bit produced by this iteration
// Revision    : 1.0 - initial release
// ============================================================================
module div_step #(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] i_rem,
    input  logic [DATA_W-1:0] i_dvd,
    input  logic [DATA_W-1:0] i_divisor,
    output logic [DATA_W-1:0] o_rem,
    output logic [DATA_W-1:0] o_dvd,
    output logic              o_qbit
);

    logic [DATA_W:0] w_shift;
    logic [DATA_W:0] w_diff;

    assign w_shift = {i_rem, i_dvd[DATA_W-1]};
    assign w_diff  = w_shift - {1'b0, i_divisor};

    // rem < divisor is invariant, so a successful subtract always leaves the
    // top bit clear and a borrow always sets it: the top bit is the borrow.
    assign o_qbit = ~w_diff[DATA_W];
    assign o_rem  = o_qbit ? w_diff[DATA_W-1:0] : w_shift[DATA_W-1:0];
    assign o_dvd  = {i_dvd[DATA_W-2:0], 1'b0};

endmodule : div_step
`default_nettype wire

// File: rtl/div_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : div_seq_ctrl
// Description : Multi-cycle integer divide sequencer for the EX stage
//               (DIV.W, DIV.WU, MOD.W, MOD.WU). Converts signed operands to
//               magnitudes, runs DATA_W restoring iterations, applies the
//               sign fix and holds a registered result until EX advances.
// Ports       : clk        - clock, all state on posedge
//               reset      - synchronous active-high reset
//               flush      - synchronous pipeline flush, same effect as reset
//               req_valid  - EX holds a valid divide op
//               req_signed - 1: signed op, 0: unsigned
//               req_mod    - 1: return remainder, 0: return quotient
//               req_src1   - dividend
//               req_src2   - divisor
//               out_ready  - EX advancing this cycle
//               div_wait   - stall EX while the op is in flight
//               div_done   - result valid
//               div_result - registered quotient / remainder
// Revision    : 1.0 - initial release
// ============================================================================
import div_seq_ctrl_pkg::*;

module div_seq_ctrl #(
    parameter int DATA_W      = 32,
    parameter bit ZERO_BYPASS = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              req_valid,
    input  logic              req_signed,
    input  logic              req_mod,
    input  logic [DATA_W-1:0] req_src1,
    input  logic [DATA_W-1:0] req_src2,
    input  logic              out_ready,
    output logic              div_wait,
    output logic              div_done,
    output logic [DATA_W-1:0] div_result
);

    localparam int              CNT_W      = div_cnt_w(DATA_W);
    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(DATA_W - 1);

    function automatic logic [DATA_W-1:0] cond_neg(input logic [DATA_W-1:0] v,
                                                   input logic              neg);
        return neg ? (~v + DATA_W'(1)) : v;
    endfunction

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [DATA_W-1:0] r_rem;
    logic [DATA_W-1:0] r_dvd;
    logic [DATA_W-1:0] r_dvs;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_q_neg;
    logic              r_r_neg;
    logic              r_mod;
    logic [DATA_W-1:0] r_result;

    logic              w_s1_neg;
    logic              w_s2_neg;
    logic              w_q_neg_in;
    logic [DATA_W-1:0] w_abs1;
    logic [DATA_W-1:0] w_abs2;
    logic              w_bypass;
    logic [DATA_W-1:0] w_byp_result;
    logic              w_last;
    logic [DATA_W-1:0] w_rem_nxt;
    logic [DATA_W-1:0] w_dvd_nxt;
    logic              w_qbit;
    logic [DATA_W-1:0] w_quot_nxt;
    logic [DATA_W-1:0] w_fix_result;

    // Operand conditioning at launch. Abs of the most negative value wraps to
    // itself, which is the correct unsigned magnitude for the datapath.
    assign w_s1_neg   = req_signed & req_src1[DATA_W-1];
    assign w_s2_neg   = req_signed & req_src2[DATA_W-1];
    assign w_q_neg_in = w_s1_neg ^ w_s2_neg;
    assign w_abs1     = cond_neg(req_src1, w_s1_neg);
    assign w_abs2     = cond_neg(req_src2, w_s2_neg);
    assign w_bypass   = ZERO_BYPASS && (req_src2 == '0);

    // Divide-by-zero short cut reproduces what the iterations would yield:
    // quotient all-ones before sign fix, remainder equal to the dividend.
    assign w_byp_result = req_mod ? cond_neg(w_abs1, w_s1_neg)
                                  : cond_neg('1, w_q_neg_in);

    div_step #(
        .DATA_W   (DATA_W)
    ) u_step (
        .i_rem    (r_rem),
        .i_dvd    (r_dvd),
        .i_divisor(r_dvs),
        .o_rem    (w_rem_nxt),
        .o_dvd    (w_dvd_nxt),
        .o_qbit   (w_qbit)
    );

    assign w_quot_nxt   = w_dvd_nxt | {{(DATA_W-1){1'b0}}, w_qbit};
    assign w_last       = (r_cnt == c_cnt_last);
    assign w_fix_result = r_mod ? cond_neg(w_rem_nxt, r_r_neg)
                                : cond_neg(w_quot_nxt, r_q_neg);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and outputs
    always_comb begin
        w_state_nxt = r_state;
        div_done    = 1'b0;
        case (r_state)
            c_st_idle: begin
                if (req_valid) begin
                    w_state_nxt = w_bypass ? c_st_done : c_st_iter;
                end
            end
            c_st_iter: begin
                // out_ready is irrelevant here: div_wait already holds EX.
                if (!req_valid) begin
                    w_state_nxt = c_st_idle;
                end else if (w_last) begin
                    w_state_nxt = c_st_done;
                end
            end
            c_st_done: begin
                div_done = 1'b1;
                if (!req_valid || out_ready) begin
                    w_state_nxt = c_st_idle;
                end
            end
            default: w_state_nxt = c_st_idle;
        endcase
        if (flush) begin
            w_state_nxt = c_st_idle;
        end
        div_wait = req_valid & (r_state != c_st_done);
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            r_rem    <= '0;
            r_dvd    <= '0;
            r_dvs    <= '0;
            r_cnt    <= '0;
            r_q_neg  <= 1'b0;
            r_r_neg  <= 1'b0;
            r_mod    <= 1'b0;
            r_result <= '0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (req_valid) begin
                        r_rem   <= '0;
                        r_dvd   <= w_abs1;
                        r_dvs   <= w_abs2;
                        r_cnt   <= '0;
                        r_q_neg <= w_q_neg_in;
                        r_r_neg <= w_s1_neg;
                        r_mod   <= req_mod;
                        if (w_bypass) begin
                            r_result <= w_byp_result;
                        end
                    end
                end
                c_st_iter: begin
                    if (req_valid) begin
                        r_rem <= w_rem_nxt;
                        r_dvd <= w_quot_nxt;
                        r_cnt <= r_cnt + CNT_W'(1);
                        if (w_last) begin
                            r_result <= w_fix_result;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign div_result = r_result;

endmodule : div_seq_ctrl
`default_nettype wire

// File: tb/tb_div_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_div_seq_ctrl
// Description : Self-checking bench for div_seq_ctrl: table of directed
//               divide vectors plus hand-written hold, flush and abort
//               sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_div_seq_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        req_valid;
    logic        req_signed;
    logic        req_mod;
    logic [31:0] req_src1;
    logic [31:0] req_src2;
    logic        out_ready;
    logic        div_wait;
    logic        div_done;
    logic [31:0] div_result;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        sgn;
        logic        md;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[18];

    always #5 clk = ~clk;

    div_seq_ctrl #(
        .DATA_W     (32),
        .ZERO_BYPASS(1'b1)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .req_valid (req_valid),
        .req_signed(req_signed),
        .req_mod   (req_mod),
        .req_src1  (req_src1),
        .req_src2  (req_src2),
        .out_ready (out_ready),
        .div_wait  (div_wait),
        .div_done  (div_done),
        .div_result(div_result)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Launch one op in the current cycle, count stall cycles until done,
    // optionally hold in DONE, then release with out_ready.
    task automatic run_op(input string tag, input logic sgn, input logic md,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input int lat, input int hold);
        int cyc;
        int waits;
        req_valid  = 1'b1;
        req_signed = sgn;
        req_mod    = md;
        req_src1   = a;
        req_src2   = b;
        out_ready  = 1'b0;
        cyc        = 0;
        waits      = 0;
        #1;
        while (!div_done && cyc < 200) begin
            if (div_wait) waits++;
            tick();
            cyc++;
            if (cyc == 1) begin
                // Latched copies must be used from here on.
                req_src1 = ~a;
                req_src2 = ~b ^ 32'h5;
                #1;
            end
        end
        check({tag, "_latency"}, cyc, lat);
        check({tag, "_wait_cycles"}, waits, lat);
        check({tag, "_result"}, div_result, exp);
        check({tag, "_wait_in_done"}, {31'b0, div_wait}, 32'd0);
        for (int h = 0; h < hold; h++) begin
            tick();
            check($sformatf("%s_hold%0d_done", tag, h), {31'b0, div_done}, 32'd1);
            check($sformatf("%s_hold%0d_result", tag, h), div_result, exp);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        req_valid = 1'b0;
        #1;
        check({tag, "_exit_done"}, {31'b0, div_done}, 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        vecs[0]  = '{1'b0, 1'b0, 32'd100,        32'd7,          32'd14,         33};
        vecs[1]  = '{1'b0, 1'b1, 32'd100,        32'd7,          32'd2,          33};
        vecs[2]  = '{1'b1, 1'b0, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  33};
        vecs[3]  = '{1'b1, 1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  33};
        vecs[4]  = '{1'b1, 1'b0, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  33};
        vecs[5]  = '{1'b1, 1'b1, 32'd7,          32'hFFFF_FFFE,  32'd1,          33};
        vecs[6]  = '{1'b1, 1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  33};
        vecs[7]  = '{1'b1, 1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          33};
        vecs[8]  = '{1'b0, 1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          33};
        vecs[9]  = '{1'b0, 1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  33};
        vecs[10] = '{1'b0, 1'b0, 32'h0000_1234,  32'd0,          32'hFFFF_FFFF,  1};
        vecs[11] = '{1'b0, 1'b1, 32'h0000_1234,  32'd0,          32'h0000_1234,  1};
        vecs[12] = '{1'b1, 1'b0, 32'hFFFF_FFF9,  32'd0,          32'd1,          1};
        vecs[13] = '{1'b1, 1'b1, 32'hFFFF_FFF9,  32'd0,          32'hFFFF_FFF9,  1};
        vecs[14] = '{1'b0, 1'b0, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  33};
        vecs[15] = '{1'b0, 1'b1, 32'hFFFF_FFFF,  32'd1,          32'd0,          33};
        vecs[16] = '{1'b0, 1'b0, 32'd0,          32'd5,          32'd0,          33};
        vecs[17] = '{1'b0, 1'b1, 32'd123456789,  32'd1000,       32'd789,        33};

        reset      = 1'b1;
        flush      = 1'b0;
        req_valid  = 1'b0;
        req_signed = 1'b0;
        req_mod    = 1'b0;
        req_src1   = '0;
        req_src2   = '0;
        out_ready  = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        #1;
        check("reset_wait", {31'b0, div_wait}, 32'd0);
        check("reset_done", {31'b0, div_done}, 32'd0);
        check("reset_result", div_result, 32'd0);

        // Table vectors, issued back to back
        for (int i = 0; i < 18; i++) begin
            run_op($sformatf("v%0d", i), vecs[i].sgn, vecs[i].md, vecs[i].a,
                   vecs[i].b, vecs[i].exp, vecs[i].lat, 0);
        end

        // DONE held for 5 cycles, then an immediate second op
        run_op("hold_100_7", 1'b0, 1'b0, 32'd100, 32'd7, 32'd14, 33, 5);
        run_op("b2b_50_5", 1'b0, 1'b0, 32'd50, 32'd5, 32'd10, 33, 0);

        // Flush part way through the iterations
        req_valid  = 1'b1;
        req_signed = 1'b0;
        req_mod    = 1'b0;
        req_src1   = 32'd100;
        req_src2   = 32'd7;
        #1;
        repeat (10) tick();
        flush = 1'b1;
        tick();
        flush     = 1'b0;
        req_valid = 1'b0;
        #1;
        check("flush_wait", {31'b0, div_wait}, 32'd0);
        check("flush_done", {31'b0, div_done}, 32'd0);
        check("flush_result_cleared", div_result, 32'd0);
        run_op("post_flush_9_3", 1'b0, 1'b0, 32'd9, 32'd3, 32'd3, 33, 0);

        // Abort in ITER: the following op must take full latency
        req_valid = 1'b1;
        req_mod   = 1'b0;
        req_src1  = 32'd100;
        req_src2  = 32'd7;
        #1;
        repeat (5) tick();
        req_valid = 1'b0;
        tick();
        check("abort_iter_done", {31'b0, div_done}, 32'd0);
        run_op("post_abort_50_5", 1'b0, 1'b0, 32'd50, 32'd5, 32'd10, 33, 0);

        // Abort in DONE: result discarded, no done afterwards
        req_valid = 1'b1;
        req_src1  = 32'd20;
        req_src2  = 32'd4;
        #1;
        repeat (33) tick();
        check("abort_done_reached", {31'b0, div_done}, 32'd1);
        check("abort_done_result", div_result, 32'd5);
        req_valid = 1'b0;
        tick();
        check("abort_done_cleared", {31'b0, div_done}, 32'd0);
        tick();
        check("abort_done_stays_idle", {31'b0, div_done}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_div_seq_ctrl
`default_nettype wire
